// File: rtl/roc_trng_pkg.sv
// Shared definitions for the ring-oscillator-race TRNG controller slice:
// sequencer state encoding, health-test repetition limit and default counter width.
package roc_trng_pkg;

    localparam int NBC_DEFAULT      = 14;
    localparam int HEALTH_REP_LIMIT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_ARM,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_SETTLE,
        ST_CAPTURE
    } state_e;

endpackage

// File: rtl/roc_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset, used to bring
// the extractor's busy flag into the system clock domain.
module roc_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/roc_trng_ctrl.sv
// Race sequencer for the roc_bxt extractor: runs races, harvests counter LSBs,
// packs them into words on a valid/ready port. Optional ROC_TRNG_CTRL_HEALTH_EN.
module roc_trng_ctrl
    import roc_trng_pkg::*;
#(
    parameter int NBC             = NBC_DEFAULT,
    parameter int WORD_W          = 32,
    parameter int BITS_PER_SAMPLE = 1,
    parameter int RST_CYCLES      = 4,
    parameter int STR_CYCLES      = 2,
    parameter int SETTLE_CYCLES   = 2,
    parameter int TIMEOUT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              bxt_rst,
    output logic              bxt_str,
    input  logic              bxt_busy,
    input  logic [NBC-1:0]    bxt_rdata,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              timeout_err,
    output logic [7:0]        sample_cnt
`ifdef ROC_TRNG_CTRL_HEALTH_EN
    ,
    output logic              health_fail
`endif
);

    localparam int SLOTS  = WORD_W / BITS_PER_SAMPLE;
    localparam int FILL_W = $clog2(SLOTS + 1);
    localparam int PH_W   = 8;

    state_e                state_q, state_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [TIMEOUT_W-1:0]  wd_q, wd_d;
    logic [WORD_W-1:0]     shreg_q, shreg_d;
    logic [FILL_W-1:0]     fill_q, fill_d, fill_inc;
    logic [WORD_W-1:0]     out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  timeout_q, timeout_d;
    logic [7:0]            sample_cnt_q, sample_cnt_d;
    logic                  bxt_rst_q, bxt_rst_d;
    logic                  bxt_str_q, bxt_str_d;
    logic                  busy_s;
    logic                  word_full;
    logic                  health_block;

    roc_sync2 u_busy_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (bxt_busy),
        .sync_o  (busy_s)
    );

    assign word_full = (fill_q == FILL_W'(SLOTS));

`ifdef ROC_TRNG_CTRL_HEALTH_EN
    logic [NBC-1:0] prev_q, prev_d;
    logic [3:0]     rep_q, rep_d;
    logic           health_q, health_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= '0;
            rep_q    <= '0;
            health_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            rep_q    <= rep_d;
            health_q <= health_d;
        end
    end

    assign health_block = health_q;
    assign health_fail  = health_q;
`else
    logic rdata_unused;
    assign rdata_unused = ^bxt_rdata[NBC-1:BITS_PER_SAMPLE];
    assign health_block = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ph_q         <= '0;
            wd_q         <= '0;
            shreg_q      <= '0;
            fill_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
            sample_cnt_q <= '0;
            bxt_rst_q    <= 1'b1;
            bxt_str_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            wd_q         <= wd_d;
            shreg_q      <= shreg_d;
            fill_q       <= fill_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            timeout_q    <= timeout_d;
            sample_cnt_q <= sample_cnt_d;
            bxt_rst_q    <= bxt_rst_d;
            bxt_str_q    <= bxt_str_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        wd_d         = wd_q;
        shreg_d      = shreg_q;
        fill_d       = fill_q;
        fill_inc     = fill_q + 1'b1;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        timeout_d    = timeout_q;
        sample_cnt_d = sample_cnt_q;
`ifdef ROC_TRNG_CTRL_HEALTH_EN
        prev_d   = prev_q;
        rep_d    = rep_q;
        health_d = health_q;
`endif

        // Accepted word retires; a word parked in the shift register takes its place.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            if (word_full && !health_block) begin
                out_data_d  = shreg_q;
                out_valid_d = 1'b1;
                fill_d      = '0;
            end
        end
        if (health_block) begin
            out_valid_d = 1'b0;
            if (word_full) begin
                fill_d = '0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && !(word_full && !health_block)) begin
                    state_d = ST_RESET;
                    ph_d    = '0;
                end
            end
            ST_RESET: begin
                ph_d = ph_q + 1'b1;
                if (ph_q == PH_W'(RST_CYCLES - 1)) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = ST_START;
                ph_d    = '0;
            end
            ST_START: begin
                ph_d = ph_q + 1'b1;
                if (ph_q == PH_W'(STR_CYCLES - 1)) begin
                    state_d = ST_WAIT_HI;
                    wd_d    = '0;
                end
            end
            ST_WAIT_HI, ST_WAIT_LO: begin
                if (&wd_q) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (state_q == ST_WAIT_HI && busy_s) begin
                        state_d = ST_WAIT_LO;
                    end else if (state_q == ST_WAIT_LO && !busy_s) begin
                        state_d = ST_SETTLE;
                        ph_d    = '0;
                    end
                end
            end
            ST_SETTLE: begin
                ph_d = ph_q + 1'b1;
                if (ph_q == PH_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d      = ST_IDLE;
                sample_cnt_d = sample_cnt_q + 8'd1;
                shreg_d      = {shreg_q[WORD_W-BITS_PER_SAMPLE-1:0],
                                bxt_rdata[BITS_PER_SAMPLE-1:0]};
                fill_d       = fill_inc;
                if (fill_inc == FILL_W'(SLOTS)) begin
                    if (health_block) begin
                        fill_d = '0;
                    end else if (!out_valid_q || out_ready) begin
                        out_data_d  = shreg_d;
                        out_valid_d = 1'b1;
                        fill_d      = '0;
                    end
                end
`ifdef ROC_TRNG_CTRL_HEALTH_EN
                prev_d = bxt_rdata;
                if (rep_q != 4'd0 && bxt_rdata == prev_q) begin
                    rep_d = (rep_q == 4'(HEALTH_REP_LIMIT)) ? rep_q : rep_q + 4'd1;
                end else begin
                    rep_d = 4'd1;
                end
                if (rep_d == 4'(HEALTH_REP_LIMIT)) begin
                    health_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        bxt_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
        bxt_str_d = (state_d == ST_START);
    end

    assign bxt_rst     = bxt_rst_q;
    assign bxt_str     = bxt_str_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign timeout_err = timeout_q;
    assign sample_cnt  = sample_cnt_q;

endmodule
